// File: rtl/mixcol_seq_if.sv
// Handshake bundle for the column-serial MixColumns engine: start side and result side.
interface mixcol_seq_if;
  logic         start_valid;
  logic         start_ready;
  logic         inv;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  modport master (
    output start_valid, inv, state_in, out_ready,
    input  start_ready, out_valid, state_out, busy
  );

  modport slave (
    input  start_valid, inv, state_in, out_ready,
    output start_ready, out_valid, state_out, busy
  );
endinterface

// File: rtl/mixcol_seq.sv
// Column-serial AES MixColumns/InvMixColumns: COLS_PER_CYCLE lanes sweep the four
// state columns from a captured source register into a registered result.
module mixcol_lane (
  input  logic        inv,
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ {3'b000, a[7], a[7], 1'b0, a[7], a[7]};
  endfunction
  function automatic logic [7:0] gm2(input logic [7:0] a);
    return xt(a);
  endfunction
  function automatic logic [7:0] gm3(input logic [7:0] a);
    return xt(a) ^ a;
  endfunction
  function automatic logic [7:0] gm9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction
  function automatic logic [7:0] gm11(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction
  function automatic logic [7:0] gm13(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction
  function automatic logic [7:0] gm14(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  logic [7:0] a [4];

  // Every output row is the row-0 equation with the input column rotated by r.
  always_comb begin
    col_o = '0;
    for (int r = 0; r < 4; r++) a[r] = col_i[31-8*r -: 8];
    for (int r = 0; r < 4; r++) begin
      if (inv)
        col_o[31-8*r -: 8] = gm14(a[r]) ^ gm11(a[(r+1)%4]) ^ gm13(a[(r+2)%4]) ^ gm9(a[(r+3)%4]);
      else
        col_o[31-8*r -: 8] = gm2(a[r]) ^ gm3(a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
  end
endmodule

module mixcol_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  mixcol_seq_if.slave  bus
);
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] src_q, src_d;
  logic [127:0] out_q, out_d;
  logic         inv_q, inv_d;

  logic [3:0][31:0] src_cols, out_cols;
  logic [COLS_PER_CYCLE-1:0][31:0] lane_in, lane_out;

  // Column c sits at src_cols[3-c]; the 2-bit index wraps naturally.
  always_comb begin
    src_cols = src_q;
    for (int k = 0; k < COLS_PER_CYCLE; k++)
      lane_in[k] = src_cols[2'd3 - (cnt_q + 2'(k))];
  end

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
    mixcol_lane u_lane (
      .inv   (inv_q),
      .col_i (lane_in[k]),
      .col_o (lane_out[k])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    src_d    = src_q;
    inv_d    = inv_q;
    out_d    = out_q;
    out_cols = out_q;
    case (state_q)
      IDLE: if (bus.start_valid) begin
        src_d   = bus.state_in;
        inv_d   = bus.inv;
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++)
          out_cols[2'd3 - (cnt_q + 2'(k))] = lane_out[k];
        out_d = out_cols;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + STEP;
        end
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      out_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      out_q   <= out_d;
      inv_q   <= inv_d;
    end
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.state_out   = out_q;
endmodule

// File: tb/tb_mixcol_seq.sv
// Bench for mixcol_seq: one instance per lane count, table vectors plus a
// GF(2^8) reference model feeding a scoreboard checked at each output handshake.
module tb_mixcol_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mixcol_seq_if b1 ();
  mixcol_seq_if b2 ();
  mixcol_seq_if b4 ();

  mixcol_seq #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));
  mixcol_seq #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .reset(reset), .bus(b2));
  mixcol_seq #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .reset(reset), .bus(b4));

  int           sel;
  logic         sv, ordy, inv;
  logic [127:0] din;

  assign b1.start_valid = sv && (sel == 0);
  assign b2.start_valid = sv && (sel == 1);
  assign b4.start_valid = sv && (sel == 2);
  assign b1.out_ready = ordy;
  assign b2.out_ready = ordy;
  assign b4.out_ready = ordy;
  assign b1.inv = inv;
  assign b2.inv = inv;
  assign b4.inv = inv;
  assign b1.state_in = din;
  assign b2.state_in = din;
  assign b4.state_in = din;

  logic         s_ready, o_valid, o_busy;
  logic [127:0] o_state;
  always_comb begin
    case (sel)
      1: begin s_ready = b2.start_ready; o_valid = b2.out_valid; o_busy = b2.busy; o_state = b2.state_out; end
      2: begin s_ready = b4.start_ready; o_valid = b4.out_valid; o_busy = b4.busy; o_state = b4.state_out; end
      default: begin s_ready = b1.start_ready; o_valid = b1.out_valid; o_busy = b1.busy; o_state = b1.state_out; end
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask
  task automatic chki(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic iv);
    logic [7:0]   m [4];
    logic [7:0]   acc;
    logic [127:0] res = '0;
    if (iv) begin m[0] = 8'd14; m[1] = 8'd11; m[2] = 8'd13; m[3] = 8'd9; end
    else    begin m[0] = 8'd2;  m[1] = 8'd3;  m[2] = 8'd1;  m[3] = 8'd1; end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(m[(j - r + 4) % 4], s[127-32*c-8*j -: 8]);
        res[127-32*c-8*r -: 8] = acc;
      end
    return res;
  endfunction

  logic [127:0] exp_q [$];
  int           acc_cyc [$];

  // Scoreboard: push the model result at each accept, compare at each output handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (sv && s_ready) begin
        exp_q.push_back(model(din, inv));
        acc_cyc.push_back(cyc + 1);
      end
      if (o_valid && ordy) begin
        if (exp_q.size() == 0) chk1("sb_unexpected_out", 1'b1, 1'b0);
        else chk("sb_result", o_state, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [127:0] d, input logic iv);
    din = d; inv = iv; sv = 1'b1;
    tick();
    sv = 1'b0;
  endtask
  task automatic wait_done(input int exp_lat, input string nm);
    int lat = 0;
    while (!o_valid && lat < 20) begin
      chk1({nm, "_busy"}, o_busy, 1'b1);
      tick();
      lat++;
    end
    chki({nm, "_latency"}, lat, exp_lat);
  endtask
  task automatic handshake();
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
  endtask
  task automatic b2b(input int n_ops, input int period, input string nm);
    int k = 0;
    acc_cyc.delete();
    ordy = 1'b1;
    sv   = 1'b1;
    while (acc_cyc.size() < n_ops && k < 200) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom);
      tick();
      k++;
    end
    sv = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin tick(); k++; end
    chki({nm, "_drained"}, exp_q.size(), 0);
    ordy = 1'b0;
    tick();
    chki({nm, "_accepts"}, acc_cyc.size(), n_ops);
    for (int i = 1; i < acc_cyc.size(); i++)
      chki({nm, "_period"}, acc_cyc[i] - acc_cyc[i-1], period);
  endtask

  typedef struct {
    logic [127:0] din;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] V_A = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] V_B = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] V_C = {16{8'hc6}};

  vec_t         tab [5];
  logic [127:0] hold, rnd;

  initial begin
    tab[0] = '{V_A, 1'b0, V_B};
    tab[1] = '{V_B, 1'b1, V_A};
    tab[2] = '{V_C, 1'b0, V_C};
    tab[3] = '{V_C, 1'b1, V_C};
    tab[4] = '{128'h0, 1'b0, 128'h0};

    sel = 0; sv = 1'b0; ordy = 1'b0; inv = 1'b0; din = '0;
    reset = 1'b1;
    #2;
    chk1("rst_start_ready", s_ready, 1'b1);
    chk1("rst_out_valid", o_valid, 1'b0);
    chk1("rst_busy", o_busy, 1'b0);
    chk("rst_state_out", o_state, 128'h0);
    #10 reset = 1'b0;
    tick();

    // Table vectors on the single-lane engine
    foreach (tab[i]) begin
      issue(tab[i].din, tab[i].inv);
      chk1("acc_start_ready", s_ready, 1'b0);
      wait_done(4, "tab");
      chk("tab_result", o_state, tab[i].exp);
      chk1("done_busy", o_busy, 1'b1);
      handshake();
      chk1("post_hs_ready", s_ready, 1'b1);
      chk1("post_hs_busy", o_busy, 1'b0);
    end

    // Backpressure: result holds, new offers ignored, then one-edge turnaround
    issue(V_A, 1'b0);
    wait_done(4, "bp");
    hold = o_state;
    chk("bp_result", hold, V_B);
    for (int i = 0; i < 10; i++) begin
      sv  = (i % 2 == 0);
      din = {$urandom, $urandom, $urandom, $urandom};
      inv = ~inv;
      tick();
      chk("bp_hold", o_state, hold);
      chk1("bp_start_ready", s_ready, 1'b0);
      chk1("bp_out_valid", o_valid, 1'b1);
    end
    sv = 1'b0;
    handshake();
    chk1("bp_idle", s_ready, 1'b1);
    chk1("bp_valid_drop", o_valid, 1'b0);
    issue(V_B, 1'b1);
    chk1("bp_next_accept", o_busy, 1'b1);
    wait_done(4, "bp2");
    chk("bp2_result", o_state, V_A);
    handshake();

    // Asynchronous reset two cycles into BUSY
    issue(V_A, 1'b0);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk1("mid_rst_start_ready", s_ready, 1'b1);
    chk1("mid_rst_out_valid", o_valid, 1'b0);
    chk1("mid_rst_busy", o_busy, 1'b0);
    chk("mid_rst_state_out", o_state, 128'h0);
    exp_q.delete();
    #3 reset = 1'b0;
    tick();
    issue(V_A, 1'b0);
    wait_done(4, "after_rst");
    chk("after_rst_result", o_state, V_B);
    handshake();

    // Input immunity: inputs churn during BUSY
    for (int m = 0; m < 2; m++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      issue(rnd, 1'(m));
      for (int i = 0; i < 8 && !o_valid; i++) begin
        inv = ~inv;
        din = {$urandom, $urandom, $urandom, $urandom};
        tick();
      end
      chk1("imm_valid", o_valid, 1'b1);
      chk("imm_result", o_state, model(rnd, 1'(m)));
      handshake();
    end

    // Two-lane engine
    sel = 1;
    issue(V_A, 1'b0);
    wait_done(2, "c2");
    chk("c2_result", o_state, V_B);
    handshake();
    b2b(5, 4, "c2_b2b");

    // Four-lane engine
    sel = 2;
    issue(V_A, 1'b0);
    wait_done(1, "c4");
    chk("c4_result", o_state, V_B);
    handshake();
    b2b(5, 3, "c4_b2b");

    chki("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mixcol_seq.md
# mixcol_seq

Column-serial MixColumns / InvMixColumns engine for the AES round datapath. It accepts a 128-bit state through a valid/ready handshake and runs `COLS_PER_CYCLE` column lanes over the four state columns under a small FSM. It returns the transformed state through a second valid/ready handshake. The lanes are built from the existing `gm2`/`gm3` (forward) and `gm9`/`gm11`/`gm13`/`gm14` (inverse) Galois multipliers, so the round controller can trade area for latency.

## Interface
- `COLS_PER_CYCLE`, default 1: columns processed per cycle. Legal values are 1, 2 and 4; any other value is an elaboration error. N = 4 / `COLS_PER_CYCLE`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start_valid` in 1: a new state is offered on `state_in`.
- `start_ready` out 1: the engine can accept a state. High only in IDLE.
- `inv` in 1: 0 selects MixColumns, 1 selects InvMixColumns. Sampled at accept.
- `state_in` in 128: input state. Byte 0 is [127:120]. Column c occupies bits [127-32c -: 32], row 0 in its MSB byte.
- `out_valid` out 1: `state_out` holds a finished result.
- `out_ready` in 1: the consumer takes the result.
- `state_out` out 128: result state, same byte ordering as `state_in`. Registered.
- `busy` out 1: high in BUSY and DONE.

## Operation
- FSM states are IDLE, BUSY and DONE.
- **IDLE:** `start_ready`=1.
  - On `start_valid`&`start_ready` at an edge: capture `state_in` into the source register and `inv` into the mode register, clear the column counter to 0, and go to BUSY.
- **BUSY:** on each edge, lanes k = 0..`COLS_PER_CYCLE`-1 transform column (cnt+k).
  - Each result is written into `state_out` at the same column position; other columns hold.
  - cnt += `COLS_PER_CYCLE`. On the edge that processes the last column group, go to DONE and clear cnt.
- Forward lane, with input column a0..a3 (a0 = row 0), all arithmetic in GF(2^8), + meaning XOR:
  - b0 = 2a0+3a1+a2+a3
  - b1 = a0+2a1+3a2+a3
  - b2 = a0+a1+2a2+3a3
  - b3 = 3a0+a1+a2+2a3
- Inverse lane:
  - b0 = 14a0+11a1+13a2+9a3
  - b1 = 9a0+14a1+11a2+13a3
  - b2 = 13a0+9a1+14a2+11a3
  - b3 = 11a0+13a1+9a2+14a3
- Lanes are 8-bit throughout with no carries.
- **DONE:** `out_valid`=1 and `state_out` is held stable.
  - On `out_valid`&`out_ready` at an edge, go to IDLE.
  - `start_ready` stays 0 in DONE, so there is no same-cycle turnaround.
- The captured `inv` and source register are immune to input changes after accept. `inv`, `state_in` and `start_valid` are ignored outside IDLE.
- `out_valid` never drops without a handshake. `state_out` changes only in BUSY.

## Timing
- Reset (asynchronous, immediate):
  - FSM goes to IDLE and cnt = 0.
  - `start_ready`=1, `out_valid`=0, `busy`=0.
  - `state_out`=128'h0, and the source and mode registers are cleared.
- Reset mid-BUSY or mid-DONE discards the operation; no partial result is ever flagged valid.
- After reset deasserts, the first edge may accept.
- Latency: accept on edge E0, column groups are written on E1..EN, and `out_valid` is high after EN.
  - N = 4, 2 or 1 for `COLS_PER_CYCLE` = 1, 2 or 4.
- With `out_ready` tied high, the result is taken at E(N+1). The earliest next accept is E(N+2), so the issue period is N+2 cycles.
- Backpressure: `out_valid` and `state_out` hold for any number of cycles with `out_ready`=0.
- `busy` and `start_ready` are decoded directly from FSM state and are glitch-free registered state bits.
- The combinational path is one lane (multiplier plus a 4-input XOR) from the source register into `state_out`. There is no path from inputs to outputs.

## Test plan
- Forward, `COLS_PER_CYCLE`=1, `inv`=0:
  - Stimulus: `state_in`=db135345_f20a225c_01010101_2d26314c.
  - Required: `state_out`=8e4da1bc_9fdc589d_01010101_4d7ebdf8; `out_valid` rises exactly 4 cycles after accept; `busy` is high from accept until the output handshake.
- Inverse, `inv`=1:
  - Stimulus: `state_in`=8e4da1bc_9fdc589d_01010101_4d7ebdf8.
  - Required: result db135345_f20a225c_01010101_2d26314c.
  - Also: an all-c6 state maps to all-c6 in both modes.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 10 cycles after `out_valid`, and pulse `start_valid` with new data during that time.
  - Required: `state_out` stays stable, `start_ready`=0, and the new data is not taken.
  - Then raise `out_ready`: IDLE on the next edge, and the next accept exactly one edge later.
- Reset mid-BUSY:
  - Stimulus: assert `reset` asynchronously 2 cycles after accept.
  - Required: all outputs go to their reset values immediately.
  - Then the forward vector from the first scenario completes correctly.
- Input immunity:
  - Stimulus: toggle `inv` and randomise `state_in` every cycle during BUSY.
  - Required: the result matches the values captured at accept.
- Parameter sweep, `COLS_PER_CYCLE`=2 and 4:
  - Stimulus: the forward vector, then back-to-back operations with `out_ready`=1.
  - Required: identical results; latency 2 and 1; accepts every 4 and 3 cycles respectively.
